fifo_write_arbiter: RTL and testbench

// - Shares the single write port of fifo_memory between NUM_REQ producers.
// - Arbitration is round-robin, with packet locking: a granted producer keeps the port

---
 rtl/fifo_write_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locking arbiter sharing one fifo_memory write port between NUM_REQ producers.
// Optional per-producer statistics counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic [NUM_REQ-1:0]                         req_valid,
    input  logic [NUM_REQ-1:0]                         req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_data,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic                                       fifo_full,
    output logic                                       fifo_write_enable,
    output logic [DATA_WIDTH-1:0]                      fifo_write_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                       burst_trunc,
    output logic [NUM_REQ*16-1:0]                      stat_beats,
    output logic [15:0]                                stat_full_stalls
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t              state_reg;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     owner_reg;
    logic [7:0]          beat_cnt_reg;
    logic                burst_trunc_reg;

    logic [2*NUM_REQ-1:0]  dbl_valid;
    logic [NUM_REQ-1:0]    rot_valid;
    logic [ID_W-1:0]       cand;
    logic                  cand_valid;
    logic                  cand_last;
    logic [DATA_WIDTH-1:0] cand_data;
    logic                  grant;
    int                    cand_off;
    int                    cand_idx;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] nxt;
        if (int'(id) >= NUM_REQ - 1) begin
            nxt = '0;
        end else begin
            nxt = id + 1'b1;
        end
        return nxt;
    endfunction

    // Rotating the valid vector by rr_ptr turns "first from rr_ptr upward" into "lowest set bit".
    assign dbl_valid = {req_valid, req_valid} >> rr_ptr_reg;
    assign rot_valid = dbl_valid[NUM_REQ-1:0];

    always_comb begin
        cand     = rr_ptr_reg;
        cand_off = 0;
        cand_idx = 0;
        if (state_reg == ST_LOCK) begin
            cand = owner_reg;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (rot_valid[k]) begin
                    cand_off = k;
                end
            end
            cand_idx = int'(rr_ptr_reg) + cand_off;
            if (cand_idx >= NUM_REQ) begin
                cand_idx = cand_idx - NUM_REQ;
            end
            cand = ID_W'(cand_idx);
        end
    end

    always_comb begin
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        cand_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(cand) == i) begin
                cand_valid = req_valid[i];
                cand_last  = req_last[i];
                cand_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Reset and full both gate the transfer combinationally; nothing reaches a full FIFO.
    assign grant             = rstn && !fifo_full && cand_valid;
    assign fifo_write_enable = grant;
    assign fifo_write_data   = grant ? cand_data : '0;
    assign grant_id          = grant ? cand : '0;
    assign burst_trunc       = burst_trunc_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant && (cand == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= ST_IDLE;
            rr_ptr_reg      <= '0;
            owner_reg       <= '0;
            beat_cnt_reg    <= 8'd0;
            burst_trunc_reg <= 1'b0;
        end else begin
            burst_trunc_reg <= 1'b0;
            if (grant) begin
                if (state_reg == ST_IDLE) begin
                    if (cand_last || (MAX_BURST_B == 8'd1)) begin
                        rr_ptr_reg      <= next_id(cand);
                        burst_trunc_reg <= !cand_last;
                    end else begin
                        state_reg    <= ST_LOCK;
                        owner_reg    <= cand;
                        beat_cnt_reg <= 8'd1;
                    end
                end else begin
                    if (cand_last || (beat_cnt_reg + 8'd1 == MAX_BURST_B)) begin
                        state_reg       <= ST_IDLE;
                        rr_ptr_reg      <= next_id(owner_reg);
                        beat_cnt_reg    <= 8'd0;
                        burst_trunc_reg <= !cand_last;
                    end else begin
                        beat_cnt_reg <= beat_cnt_reg + 8'd1;
                    end
                end
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stalls_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [15:0] beats_reg;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    beats_reg <= 16'd0;
                end else if (req_ready[gi] && req_valid[gi] && (beats_reg != 16'hFFFF)) begin
                    beats_reg <= beats_reg + 16'd1;
                end
            end
            assign stat_beats[gi*16 +: 16] = beats_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stalls_reg <= 16'd0;
        end else if ((|req_valid) && fifo_full && (stalls_reg != 16'hFFFF)) begin
            stalls_reg <= stalls_reg + 16'd1;
        end
    end
    assign stat_full_stalls = stalls_reg;
`else
    assign stat_beats       = '0;
    assign stat_full_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a 32-deep behavioural FIFO in front of it.
// Stats expectations follow FIFO_ARB_STATS_EN.
module tb_fifo_write_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int MB    = 8;
`ifdef FIFO_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_last;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          fifo_full;
    logic          fifo_write_enable;
    logic [DW-1:0] fifo_write_data;
    logic [1:0]    grant_id;
    logic          burst_trunc;
    logic [NR*16-1:0] stat_beats;
    logic [15:0]   stat_full_stalls;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .req_valid         (req_valid),
        .req_last          (req_last),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .grant_id          (grant_id),
        .burst_trunc       (burst_trunc),
        .stat_beats        (stat_beats),
        .stat_full_stalls  (stat_full_stalls)
    );

    // Behavioural stand-in for fifo_memory (depth 32).
    logic [7:0] fifo_mem [32];
    logic [5:0] fifo_count;
    logic [4:0] wr_ptr, rd_ptr;
    logic       fifo_rd, fifo_clr;
    logic       overflow_seen = 1'b0;
    logic       push, pop;

    assign fifo_full = (fifo_count == 6'd32);
    assign push      = fifo_write_enable && !fifo_full;
    assign pop       = fifo_rd && (fifo_count != 6'd0);

    always @(posedge clk) begin
        if (fifo_clr) begin
            fifo_count <= 6'd0;
            wr_ptr     <= 5'd0;
            rd_ptr     <= 5'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= fifo_write_data;
                wr_ptr <= wr_ptr + 5'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 5'd1;
            end
            fifo_count <= fifo_count + 6'(push) - 6'(pop);
        end
        overflow_seen <= overflow_seen | (fifo_write_enable && fifo_full);
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic [3:0]  ready;
        logic        we;
        logic [7:0]  wdata;
        logic [1:0]  gid;
        logic        trunc;
    } vec_t;

    vec_t vecs [64];
    int   n_vec = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic [3:0] r, input logic w, input logic [7:0] wd,
                       input logic [1:0] g, input logic t);
        vecs[n_vec] = '{valid: v, last: l, data: d, ready: r, we: w, wdata: wd, gid: g, trunc: t};
        n_vec++;
    endtask

    // Drive at posedge+1, sample at the falling edge, return at next posedge+1.
    task automatic apply_row(input int n);
        req_valid = vecs[n].valid;
        req_last  = vecs[n].last;
        req_data  = vecs[n].data;
        #4;
        chk($sformatf("v%0d_ready", n), 64'(req_ready), 64'(vecs[n].ready));
        chk($sformatf("v%0d_we", n), 64'(fifo_write_enable), 64'(vecs[n].we));
        chk($sformatf("v%0d_wdata", n), 64'(fifo_write_data), 64'(vecs[n].wdata));
        chk($sformatf("v%0d_gid", n), 64'(grant_id), 64'(vecs[n].gid));
        chk($sformatf("v%0d_trunc", n), 64'(burst_trunc), 64'(vecs[n].trunc));
        $display("vec %0d: valid=%b ready=%b we=%b data=%h gid=%0d trunc=%b",
                 n, req_valid, req_ready, fifo_write_enable, fifo_write_data, grant_id, burst_trunc);
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_read(output logic [7:0] d);
        d = fifo_mem[rd_ptr];
        fifo_rd = 1'b1;
        @(posedge clk);
        #1;
        fifo_rd = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        int s1_end;

        // Round-robin with single-beat packets.
        for (int i = 0; i < 8; i++) begin
            add(4'hF, 4'hF, 32'hA3A2A1A0, 4'(1 << (i % 4)), 1'b1, 8'(8'hA0 + i % 4), 2'(i % 4), 1'b0);
        end
        s1_end = n_vec;
        // Lock on producer 2 while producer 0 keeps asking.
        add(4'b0001, 4'b0001, 32'h00000055, 4'b0001, 1'b1, 8'h55, 2'd0, 1'b0);
        add(4'b0101, 4'b0001, 32'h00110055, 4'b0100, 1'b1, 8'h11, 2'd2, 1'b0);
        add(4'b0101, 4'b0001, 32'h00220055, 4'b0100, 1'b1, 8'h22, 2'd2, 1'b0);
        add(4'b0001, 4'b0001, 32'h00000055, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        add(4'b0101, 4'b0101, 32'h00330055, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b0);
        add(4'b1001, 4'b1001, 32'h77000055, 4'b1000, 1'b1, 8'h77, 2'd3, 1'b0);
        add(4'b0001, 4'b0001, 32'h00000055, 4'b0001, 1'b1, 8'h55, 2'd0, 1'b0);
        // Producer 1 streams without last: cut after 8, re-granted, cut again after 8 more.
        for (int k = 0; k < 16; k++) begin
            add(4'b0010, 4'b0000, {16'h0, 8'(8'h40 + k), 8'h00}, 4'b0010, 1'b1,
                8'(8'h40 + k), 2'd1, 1'(k == 8));
        end
        add(4'b0000, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1);

        rstn      = 1'b0;
        fifo_clr  = 1'b1;
        fifo_rd   = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = 32'hA3A2A1A0;
        @(posedge clk);
        #7;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we", 64'(fifo_write_enable), 64'd0);
        chk("rst_wdata", 64'(fifo_write_data), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_trunc", 64'(burst_trunc), 64'd0);
        chk("rst_stat_beats", stat_beats, 64'd0);
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        fifo_clr = 1'b0;

        for (int n = 0; n < s1_end; n++) apply_row(n);
        req_valid = 4'h0;
        chk("s1_fifo_count", 64'(fifo_count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            fifo_read(rd);
            chk($sformatf("s1_fifo_%0d", i), 64'(rd), 64'(8'hA0 + i % 4));
            $display("s1 read %0d: data=%h", i, rd);
        end
        chk("s1_stat_beats", stat_beats, STATS ? {4{16'd2}} : 64'd0);

        for (int n = s1_end; n < n_vec; n++) apply_row(n);

        // Fill the FIFO from producer 0, then hit full.
        fifo_clr = 1'b1;
        @(posedge clk);
        #1;
        fifo_clr = 1'b0;
        req_last = 4'b0001;
        for (int k = 0; k < 32; k++) begin
            req_valid = 4'b0001;
            req_data  = {24'h0, 8'(k)};
            #4;
            chk($sformatf("s4_we_%0d", k), 64'(fifo_write_enable), 64'd1);
            chk($sformatf("s4_wdata_%0d", k), 64'(fifo_write_data), 64'(k));
            $display("s4 write %0d: we=%b data=%h", k, fifo_write_enable, fifo_write_data);
            @(posedge clk);
            #1;
        end
        chk("s4_full", 64'(fifo_full), 64'd1);
        req_data = 32'h000000EE;
        for (int s = 0; s < 5; s++) begin
            #4;
            chk($sformatf("s4_stall_ready_%0d", s), 64'(req_ready), 64'd0);
            chk($sformatf("s4_stall_we_%0d", s), 64'(fifo_write_enable), 64'd0);
            $display("s4 stall %0d: ready=%b we=%b", s, req_ready, fifo_write_enable);
            @(posedge clk);
            #1;
        end
        req_valid = 4'b0000;
        chk("s4_stat_stalls", 64'(stat_full_stalls), STATS ? 64'd5 : 64'd0);
        fifo_read(rd);
        chk("s4_head", 64'(rd), 64'd0);
        req_valid = 4'b0001;
        #4;
        chk("s4_retry_ready", 64'(req_ready), 64'b0001);
        chk("s4_retry_we", 64'(fifo_write_enable), 64'd1);
        chk("s4_retry_wdata", 64'(fifo_write_data), 64'hEE);
        $display("s4 retry: ready=%b we=%b data=%h", req_ready, fifo_write_enable, fifo_write_data);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;

        // Reset in the middle of a producer-3 packet.
        fifo_clr = 1'b1;
        @(posedge clk);
        #1;
        fifo_clr  = 1'b0;
        req_last  = 4'b0000;
        req_valid = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            req_data = {8'(8'h31 + k), 24'h00005A};
            #4;
            chk($sformatf("s5_beat_ready_%0d", k), 64'(req_ready), 64'b1000);
            $display("s5 beat %0d: ready=%b gid=%0d", k, req_ready, grant_id);
            @(posedge clk);
            #1;
        end
        req_valid = 4'b1001;
        #1;
        chk("s5_locked_ready", 64'(req_ready), 64'b1000);
        rstn = 1'b0;
        #1;
        chk("s5_rst_ready", 64'(req_ready), 64'd0);
        chk("s5_rst_we", 64'(fifo_write_enable), 64'd0);
        chk("s5_rst_gid", 64'(grant_id), 64'd0);
        chk("s5_rst_wdata", 64'(fifo_write_data), 64'd0);
        #2;
        rstn = 1'b1;
        #1;
        chk("s5_post_ready", 64'(req_ready), 64'b0001);
        chk("s5_post_gid", 64'(grant_id), 64'd0);
        chk("s5_post_wdata", 64'(fifo_write_data), 64'h5A);
        chk("s5_post_stat_beats", stat_beats, 64'd0);
        $display("s5 after reset: ready=%b gid=%0d data=%h", req_ready, grant_id, fifo_write_data);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;

        chk("no_overflow", 64'(overflow_seen), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
